// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the truth-table sweeper and its golden-value LUT.
package truth_table_pkg;

    localparam int RULE_W      = 8;
    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/lut3_cell.sv
// Combinational 3-input lookup: input index i selects rule[7-i], so the rule
// byte reads MSB-first as the truth table from {in1,in2,in3}=000 to 111.
module lut3_cell
    import truth_table_pkg::*;
(
    input  logic [RULE_W-1:0] rule_i,
    input  logic [IDX_W-1:0]  in_i,
    output logic              out_o
);

    // 7-i equals the bitwise complement of a 3-bit index
    always_comb begin
        out_o = rule_i[~in_i];
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all eight input vectors of a 3-input logic block, captures its
// response, and compares it against a latched golden truth table.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [RULE_W-1:0]   rule,
    input  logic [SETTLE_W-1:0] settle,
    output logic [IDX_W-1:0]    dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic [RULE_W-1:0]   captured,
    output logic                pass,
    output logic                fail_valid,
    output logic [IDX_W-1:0]    first_fail
);

    state_t              state_q;
    logic [RULE_W-1:0]   rule_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settleCnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic                busy_q;
    logic                done_q;
    logic [RULE_W-1:0]   captured_q;
    logic                pass_q;
    logic                failValid_q;
    logic [IDX_W-1:0]    firstFail_q;
    logic                golden;

    lut3_cell u_golden (
        .rule_i (rule_q),
        .in_i   (idx_q),
        .out_o  (golden)
    );

    // A single sequential block owns the whole sweep; abort overrides any
    // non-idle state so a DONE cycle being aborted produces no done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rule_q      <= '0;
            settle_q    <= '0;
            settleCnt_q <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            captured_q  <= '0;
            pass_q      <= 1'b0;
            failValid_q <= 1'b0;
            firstFail_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && abort) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                pass_q      <= 1'b0;
                settleCnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            rule_q      <= rule;
                            settle_q    <= settle;
                            idx_q       <= '0;
                            captured_q  <= '0;
                            pass_q      <= 1'b0;
                            failValid_q <= 1'b0;
                            firstFail_q <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        if (settle_q != '0) begin
                            settleCnt_q <= settle_q;
                            state_q     <= SETTLE;
                        end else begin
                            state_q     <= SAMPLE;
                        end
                    end
                    SETTLE: begin
                        settleCnt_q <= settleCnt_q - SETTLE_W'(1);
                        if (settleCnt_q == SETTLE_W'(1)) begin
                            state_q <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        captured_q[~idx_q] <= dut_out;
                        if (dut_out != golden && !failValid_q) begin
                            failValid_q <= 1'b1;
                            firstFail_q <= idx_q;
                        end
                        if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= DRIVE;
                        end
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        pass_q  <= (captured_q == rule_q);
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign dut_in     = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign captured   = captured_q;
    assign pass       = pass_q;
    assign fail_valid = failValid_q;
    assign first_fail = firstFail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a lut3_cell stands in for the logic block under test and a
// scoreboard queue holds the expected result of every launched sweep.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] rule;
    logic [7:0] settle;
    logic [2:0] dutIn;
    logic       dutOut;
    logic       busy;
    logic       done;
    logic [7:0] captured;
    logic       pass;
    logic       failValid;
    logic [2:0] firstFail;
    logic [7:0] modelRule;
    logic       tieHigh;
    logic       modelOut;

    typedef struct {
        logic [7:0] captured;
        logic       pass;
        logic       failValid;
        logic [2:0] firstFail;
        int         latency;
    } expect_t;

    expect_t sbQ[$];
    int      vectors     = 0;
    int      miscompares = 0;

    always #5 clk = ~clk;

    lut3_cell u_model (
        .rule_i (modelRule),
        .in_i   (dutIn),
        .out_o  (modelOut)
    );

    assign dutOut = tieHigh ? 1'b1 : modelOut;

    truth_table_sweeper #(.SETTLE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .rule       (rule),
        .settle     (settle),
        .dut_in     (dutIn),
        .dut_out    (dutOut),
        .busy       (busy),
        .done       (done),
        .captured   (captured),
        .pass       (pass),
        .fail_valid (failValid),
        .first_fail (firstFail)
    );

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("[TB] %s miscompare", tag);
        end
    endtask

    task automatic checkResetValues(input string tag);
        compare({tag, "_busy"},       busy,      0);
        compare({tag, "_done"},       done,      0);
        compare({tag, "_captured"},   captured,  0);
        compare({tag, "_pass"},       pass,      0);
        compare({tag, "_fail_valid"}, failValid, 0);
        compare({tag, "_first_fail"}, firstFail, 0);
        compare({tag, "_dut_in"},     dutIn,     0);
    endtask

    // Called #1 after a posedge; returns #1 after the edge that accepted start.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] s,
                                 input logic [7:0] mr, input logic tie);
        expect_t    e;
        logic [7:0] cap;
        cap         = tie ? 8'hFF : mr;
        e.captured  = cap;
        e.pass      = (cap == r);
        e.failValid = 1'b0;
        e.firstFail = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cap[7-i] !== r[7-i]) begin
                e.failValid = 1'b1;
                e.firstFail = 3'(i);
            end
        end
        e.latency = 8 * (int'(s) + 2) + 1;
        sbQ.push_back(e);
        modelRule = mr;
        tieHigh   = tie;
        rule      = r;
        settle    = s;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        compare("busy_after_accept", busy, 1);
    endtask

    task automatic checkOutput(input int settleVal, input logic checkRuns);
        expect_t    e;
        int         n;
        int         runLen;
        int         runs;
        int         badRuns;
        logic       seen;
        logic [2:0] lastIn;
        e       = sbQ.pop_front();
        n       = 0;
        runs    = 0;
        badRuns = 0;
        seen    = 1'b0;
        lastIn  = dutIn;
        runLen  = 1;
        while (!seen && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else if (dutIn === lastIn) begin
                runLen++;
            end else begin
                runs++;
                if (runLen != settleVal + 2) badRuns++;
                lastIn = dutIn;
                runLen = 1;
            end
        end
        compare("done_seen", seen, 1);
        if (seen) begin
            compare("latency",    n,         e.latency);
            compare("captured",   captured,  e.captured);
            compare("pass",       pass,      e.pass);
            compare("fail_valid", failValid, e.failValid);
            compare("first_fail", firstFail, e.firstFail);
            compare("busy_at_done", busy, 0);
        end
        if (checkRuns) begin
            compare("dut_in_runs",     runs,    7);
            compare("dut_in_bad_runs", badRuns, 0);
        end
        @(posedge clk);
        #1;
        compare("done_single_cycle", done, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        logic doneSeen;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        rule      = 8'h00;
        settle    = 8'h00;
        modelRule = 8'h00;
        tieHigh   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] matching sweep, settle 0");
        applyStimulus(8'hD3, 8'd0, 8'hD3, 1'b0);
        checkOutput(0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        compare("hold_captured", captured, 8'hD3);
        compare("hold_pass",     pass,     1);
        compare("hold_busy",     busy,     0);

        $display("[TB] mismatching block");
        applyStimulus(8'hD3, 8'd0, 8'hD1, 1'b0);
        checkOutput(0, 1'b0);

        $display("[TB] settle 3 timing");
        applyStimulus(8'h6B, 8'd3, 8'h6B, 1'b0);
        checkOutput(3, 1'b1);

        $display("[TB] output stuck high");
        applyStimulus(8'h00, 8'd0, 8'h00, 1'b1);
        checkOutput(0, 1'b0);

        $display("[TB] ignored restart and abort");
        modelRule = 8'h3C;
        tieHigh   = 1'b0;
        rule      = 8'h2C;
        settle    = 8'd1;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rule   = 8'h00;
        settle = 8'd0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 3;
        while (dutIn !== 3'd4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        compare("idx4_reached_cycle", n, 12);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        compare("abort_busy",       busy,      0);
        compare("abort_done",       done,      0);
        compare("abort_pass",       pass,      0);
        compare("abort_captured",   captured,  8'h30);
        compare("abort_fail_valid", failValid, 1);
        compare("abort_first_fail", firstFail, 3);
        doneSeen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneSeen = 1'b1;
        end
        compare("abort_no_done", doneSeen, 0);
        applyStimulus(8'h96, 8'd2, 8'h96, 1'b0);
        checkOutput(2, 1'b0);

        $display("[TB] reset during settle");
        modelRule = 8'h5A;
        rule      = 8'hA5;
        settle    = 8'd4;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        compare("pre_reset_fail_valid", failValid, 1);
        compare("pre_reset_dut_in",     dutIn,     1);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues("mid_reset");
        rst   = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        compare("start_abort_busy", busy, 0);
        @(posedge clk);
        #1;
        compare("start_abort_busy_late", busy, 0);
        compare("start_abort_dut_in",    dutIn, 0);
        start = 1'b0;
        abort = 1'b0;

        compare("scoreboard_empty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
